// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: responder FSM states, default timing (100 MHz cycles)
// and the frame checksum used by both the responder and the host reader.
package dht11_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStartDet,
        StGap,
        StPresLow,
        StPresHigh,
        StBitLow,
        StBitHigh,
        StEndLow
    } dht11_state_e;

    localparam int unsigned DHT11_START_MIN  = 1_000_000;
    localparam int unsigned DHT11_RESP_WAIT  = 3_000;
    localparam int unsigned DHT11_RESP_LOW   = 8_000;
    localparam int unsigned DHT11_RESP_HIGH  = 8_000;
    localparam int unsigned DHT11_BIT_LOW    = 5_000;
    localparam int unsigned DHT11_BIT_HIGH_0 = 2_700;
    localparam int unsigned DHT11_BIT_HIGH_1 = 7_000;

    // Modulo-256 sum; the carry is dropped by the 8-bit return type.
    function automatic logic [7:0] dht11_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2, input logic [7:0] b3);
        return b0 + b1 + b2 + b3;
    endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the DHT11 data line with rise/fall pulses
// derived from the synchronized value.
module dht11_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    // Reset to 1 so an idle, pulled-up line never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse, answers with presence and a 40-bit frame.
// Optional macro DHT11_RESP_DECIMAL_EN sends hum_dec/temp_dec instead of zero decimal bytes.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int unsigned START_MIN  = DHT11_START_MIN,
    parameter int unsigned RESP_WAIT  = DHT11_RESP_WAIT,
    parameter int unsigned RESP_LOW   = DHT11_RESP_LOW,
    parameter int unsigned RESP_HIGH  = DHT11_RESP_HIGH,
    parameter int unsigned BIT_LOW    = DHT11_BIT_LOW,
    parameter int unsigned BIT_HIGH_0 = DHT11_BIT_HIGH_0,
    parameter int unsigned BIT_HIGH_1 = DHT11_BIT_HIGH_1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_dec,
    inout  wire        dht11_data,
    output logic       busy,
    output logic       frame_done
);

    logic line_sync, line_rise, line_fall;

    dht11_line_sync u_line_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (dht11_data),
        .sync  (line_sync),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    logic [7:0] hum_byte, temp_byte;
`ifdef DHT11_RESP_DECIMAL_EN
    assign hum_byte  = hum_dec;
    assign temp_byte = temp_dec;
    logic unused_fall;
    assign unused_fall = line_fall;
`else
    assign hum_byte  = 8'h00;
    assign temp_byte = 8'h00;
    logic unused_in;
    assign unused_in = ^{hum_dec, temp_dec, line_fall};
`endif

    logic [39:0] frame;
    assign frame = {humidity, hum_byte, temperature, temp_byte,
                    dht11_checksum(humidity, hum_byte, temperature, temp_byte)};

    dht11_state_e state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [5:0]   bit_idx_q, bit_idx_d;
    logic [39:0]  shreg_q, shreg_d;
    logic         drive_low_q, drive_low_d;
    logic         busy_q, busy_d;
    logic         frame_done_q, frame_done_d;
    logic [31:0]  phase_len;
    logic         phase_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            drive_low_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            drive_low_q  <= drive_low_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        phase_len = 32'd1;
        unique case (state_q)
            StGap:      phase_len = RESP_WAIT;
            StPresLow:  phase_len = RESP_LOW;
            StPresHigh: phase_len = RESP_HIGH;
            StBitLow:   phase_len = BIT_LOW;
            StBitHigh:  phase_len = shreg_q[39] ? BIT_HIGH_1 : BIT_HIGH_0;
            StEndLow:   phase_len = BIT_LOW;
            default:    phase_len = 32'd1;
        endcase
    end

    assign phase_end = (cnt_q == phase_len - 32'd1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!line_sync) begin
                    state_d = StStartDet;
                    cnt_d   = '0;
                end
            end
            StStartDet: begin
                if (line_rise) begin
                    cnt_d = '0;
                    if (cnt_q >= START_MIN) begin
                        shreg_d = frame;
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                // Timed phases: the line is no longer observed until the frame ends.
                cnt_d = phase_end ? '0 : cnt_q + 32'd1;
                if (phase_end) begin
                    unique case (state_q)
                        StGap:      state_d = StPresLow;
                        StPresLow:  state_d = StPresHigh;
                        StPresHigh: begin
                            state_d   = StBitLow;
                            bit_idx_d = 6'd39;
                        end
                        StBitLow:   state_d = StBitHigh;
                        StBitHigh: begin
                            shreg_d = {shreg_q[38:0], 1'b0};
                            if (bit_idx_q == 6'd0) begin
                                state_d = StEndLow;
                            end else begin
                                bit_idx_d = bit_idx_q - 6'd1;
                                state_d   = StBitLow;
                            end
                        end
                        StEndLow: begin
                            state_d      = StIdle;
                            frame_done_d = 1'b1;
                        end
                        default:    state_d = StIdle;
                    endcase
                end
            end
        endcase

        drive_low_d = (state_d == StPresLow) || (state_d == StBitLow) || (state_d == StEndLow);
        busy_d      = (state_d != StIdle) && (state_d != StStartDet);
    end

    assign dht11_data = drive_low_q ? 1'b0 : 1'bz;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder with shortened timing; decodes the line like a host.
module tb_dht11_responder;

    localparam int unsigned T_START = 20;
    localparam int unsigned T_WAIT  = 4;
    localparam int unsigned T_PLOW  = 8;
    localparam int unsigned T_PHIGH = 6;
    localparam int unsigned T_BLOW  = 5;
    localparam int unsigned T_H0    = 3;
    localparam int unsigned T_H1    = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] humidity = 8'h00;
    logic [7:0] temperature = 8'h00;
    logic [7:0] hum_dec = 8'h00;
    logic [7:0] temp_dec = 8'h00;
    logic       busy, frame_done;
    wire        dht_line;

    pullup (dht_line);
    assign dht_line = host_low ? 1'b0 : 1'bz;

    dht11_responder #(
        .START_MIN  (T_START),
        .RESP_WAIT  (T_WAIT),
        .RESP_LOW   (T_PLOW),
        .RESP_HIGH  (T_PHIGH),
        .BIT_LOW    (T_BLOW),
        .BIT_HIGH_0 (T_H0),
        .BIT_HIGH_1 (T_H1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .humidity    (humidity),
        .temperature (temperature),
        .hum_dec     (hum_dec),
        .temp_dec    (temp_dec),
        .dht11_data  (dht_line),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    int busy_gap = 0;
    bit in_frame = 1'b0;
    int poke_bit = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) fd_cnt++;
            if (in_frame && !busy) busy_gap++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Current sample is already at lvl; returns its run length in cycles.
    task automatic measure(input logic lvl, output int n, output bit ok);
        n  = 1;
        ok = 1'b1;
        forever begin
            @(negedge clk);
            if (dht_line !== lvl) break;
            n++;
            if (n > 2000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic host_start(input int low_cycles);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_cycles) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_presence(input string tag, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (dht_line === 1'b0) begin
                n  = k;
                ok = 1'b1;
                break;
            end
        end
        check({tag, ".gap"}, n, 3 + T_WAIT);
    endtask

    task automatic run_frame(input string tag, input logic [39:0] exp);
        int n, lo_err, hi_err;
        bit ok;
        logic [39:0] got;
        fd_cnt = 0;
        busy_gap = 0;
        lo_err = 0;
        hi_err = 0;
        got = '0;
        host_start(40);
        wait_presence(tag, ok);
        if (!ok) return;
        in_frame = 1'b1;
        measure(1'b0, n, ok);
        check({tag, ".pres_low"}, n, T_PLOW);
        measure(1'b1, n, ok);
        check({tag, ".pres_high"}, n, T_PHIGH);
        for (int i = 39; i >= 0; i--) begin
            measure(1'b0, n, ok);
            if (n != T_BLOW) lo_err++;
            measure(1'b1, n, ok);
            if (!ok) break;
            got[i] = (n > (T_H0 + T_H1) / 2);
            if (n != (exp[i] ? T_H1 : T_H0)) hi_err++;
            if (i == poke_bit) humidity = 8'h99;
        end
        in_frame = 1'b0;
        if (!ok) begin
            check({tag, ".timeout"}, 64'd1, 64'd0);
            return;
        end
        measure(1'b0, n, ok);
        check({tag, ".end_low"}, n, T_BLOW);
        check({tag, ".done_at_release"}, frame_done, 1'b1);
        check({tag, ".busy_at_release"}, busy, 1'b0);
        @(negedge clk);
        check({tag, ".done_pulses"}, fd_cnt, 1);
        check({tag, ".busy_dropouts"}, busy_gap, 0);
        check({tag, ".data"}, got, exp);
        check({tag, ".bit_low_timing"}, lo_err, 0);
        check({tag, ".bit_high_timing"}, hi_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo_cnt, busy_cnt, n;
        bit ok;

        repeat (3) @(negedge clk);
        check("reset.busy", busy, 1'b0);
        check("reset.frame_done", frame_done, 1'b0);
        check("reset.line", dht_line, 1'b1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        humidity = 8'h37;
        temperature = 8'h19;
        run_frame("basic", 40'h37_00_19_00_50);
        repeat (10) @(negedge clk);

        // Too-short start pulse must be ignored.
        lo_cnt = 0;
        busy_cnt = 0;
        host_start(5);
        repeat (100) begin
            @(negedge clk);
            if (dht_line === 1'b0) lo_cnt++;
            if (busy) busy_cnt++;
        end
        check("short.line_driven", lo_cnt, 0);
        check("short.busy", busy_cnt, 0);

        poke_bit = 20;
        run_frame("latched", 40'h37_00_19_00_50);
        poke_bit = -1;
        repeat (10) @(negedge clk);

        humidity = 8'hC8;
        temperature = 8'h64;
        run_frame("carry", 40'hC8_00_64_00_2C);
        repeat (10) @(negedge clk);

        // Reset during the first bit's low phase.
        humidity = 8'h37;
        temperature = 8'h19;
        host_start(40);
        wait_presence("rst", ok);
        if (ok) begin
            measure(1'b0, n, ok);
            measure(1'b1, n, ok);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("rst.line_released", dht_line, 1'b1);
            check("rst.busy", busy, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (10) @(negedge clk);
        run_frame("after_rst", 40'h37_00_19_00_50);
        repeat (10) @(negedge clk);

        hum_dec = 8'h05;
        temp_dec = 8'h03;
`ifdef DHT11_RESP_DECIMAL_EN
        run_frame("decimal", 40'h37_05_19_03_58);
`else
        run_frame("decimal", 40'h37_00_19_00_50);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Single-wire DHT11 sensor emulator: the responder end of the DHT11 host protocol. It watches the shared open-drain data line for a host start pulse, then answers with the 80 µs/80 µs presence handshake and a 40-bit frame (humidity, temperature, checksum) built from values on its input ports. It sits in loopback builds and benches opposite the DHT11 host reader, so host timing can be exercised without a physical sensor. Clock is 100 MHz; all timing parameters are in clock cycles.

## Interface
- `START_MIN`, default 1_000_000: minimum host low time (10 ms) accepted as a start request.
- `RESP_WAIT`, default 3_000: release gap (30 µs) after the host releases the line.
- `RESP_LOW`, default 8_000: presence low (80 µs).
- `RESP_HIGH`, default 8_000: presence high (80 µs).
- `BIT_LOW`, default 5_000: per-bit low (50 µs).
- `BIT_HIGH_0`, default 2_700: high time for a 0 bit (27 µs).
- `BIT_HIGH_1`, default 7_000: high time for a 1 bit (70 µs).
- `clk  in  1`: 100 MHz clock.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `humidity  in  8`: integer humidity byte.
- `temperature  in  8`: integer temperature byte.
- `hum_dec  in  8`: decimal humidity byte. Used only with the macro (see Configuration).
- `temp_dec  in  8`: decimal temperature byte. Used only with the macro.
- `dht11_data  inout  1`: open-drain bus. The block drives `0` or `'z'` only; the pull-up is external or a bench `pullup`.
- `busy  out  1`: high from start acceptance until the final release.
- `frame_done  out  1`: one-cycle pulse at the final release.

## Operation
- Input path: `dht11_data` passes through a 2-flop synchronizer. Edge detection uses the synchronized value only.
- `drive_low` register: `dht11_data = drive_low ? 0 : 'z`.
- States: `IDLE`, `START_DET`, `GAP`, `PRES_LOW`, `PRES_HIGH`, `BIT_LOW`, `BIT_HIGH`, `END_LOW`.
- `IDLE`:
  - Line released; waits for the synchronized line to read low.
  - On low: go to `START_DET`, cycle counter = 0.
- `START_DET`: counts low cycles.
  - Rising edge with count ≥ `START_MIN`: latch the frame into a 40-bit shift register, assert `busy`, go to `GAP`.
  - Rising edge with count < `START_MIN`: back to `IDLE`, no response.
  - Counter saturates; it never wraps.
- Frame, MSB first: `{humidity, hum_dec', temperature, temp_dec', checksum}`.
  - `checksum` = 8-bit sum of the four preceding bytes, modulo 256 (carry discarded).
  - `hum_dec'` and `temp_dec'` are the decimal bytes, or 0 without the macro.
- `GAP`: released for `RESP_WAIT` cycles, then `PRES_LOW`.
- `PRES_LOW`: drive low for `RESP_LOW` cycles, then `PRES_HIGH`.
- `PRES_HIGH`: release for `RESP_HIGH` cycles, then `BIT_LOW` with bit index = 39.
- `BIT_LOW`: drive low for `BIT_LOW` cycles, then `BIT_HIGH`.
- `BIT_HIGH`: release for `BIT_HIGH_1` cycles if the current bit is 1, else `BIT_HIGH_0`.
  - Then shift; at index 0 go to `END_LOW`, otherwise back to `BIT_LOW`.
- `END_LOW`: drive low `BIT_LOW` cycles, then release. Pulse `frame_done`, clear `busy`, go to `IDLE`.
- Input changes after the latch do not affect the frame in flight.
- The line is ignored in all states after `START_DET`; a host driving low during a frame is not detected.

## Timing
- Reset values: `drive_low`=0 (line released), `busy`=0, `frame_done`=0, state `IDLE`, counters and shift register 0.
- Reset mid-frame releases the line asynchronously. After reset deassertion the block is in `IDLE` and needs a fresh start pulse.
- Synchronizer latency is 2 cycles, so `busy` rises 3 cycles after the host's actual rising edge.
- Each phase lasts exactly its parameter in cycles (counter compare at `param-1`). There are no idle cycles between phases.
- Total frame after `GAP` = `RESP_LOW + RESP_HIGH + 40*BIT_LOW + Σ bit-high + BIT_LOW`.
- `frame_done` is high in the same cycle that `drive_low` falls to 0 after `END_LOW`.

## Configuration
- `DHT11_RESP_DECIMAL_EN` defined: `hum_dec` and `temp_dec` are sent in bytes 2 and 4 and included in the checksum.
- Not defined: both bytes are sent as 0x00, the ports are ignored, and the checksum covers the integer bytes only.

## Structure
- `dht11_pkg` holds:
  - the state enum;
  - default timing constants, shared with the host reader so both ends agree;
  - a `dht11_checksum()` function.
- Sub-module `dht11_line_sync` contains the 2-flop synchronizer plus rise/fall detect pulses.

## Test plan
- Host low 18 ms then release; `humidity`=0x37, `temperature`=0x19 → 80/80 µs presence, then bytes 0x37, 0x00, 0x19, 0x00, 0x50. `frame_done` pulses once; `busy` high throughout.
- Host low 1 ms (< `START_MIN`) → line never driven, `busy` stays 0, block stays in `IDLE`.
- `humidity` changed from 0x37 to 0x99 mid-frame → transmitted frame still carries 0x37 and checksum 0x50.
- `humidity`=0xC8, `temperature`=0x64 → checksum 0x2C (carry dropped).
- `rst_n` pulsed low during `BIT_LOW` → line released the same cycle, `busy`=0. The next valid start yields a complete, correct frame.
- With macro: `hum_dec`=0x05, `temp_dec`=0x03, integers 0x37/0x19 → bytes 0x37, 0x05, 0x19, 0x03, 0x58.
